regfile_dump_reader: RTL and testbench

- Reads a range of registers through the register file's debug read port and sends their contents out as a byte stream with a valid/ready handshake.
- The downstream consumer is the UART/LED debug transmitter.
- Sits beside the 32x32 register file. The register file's debug clock is tied to this block's clock, so the two share one clock domain.
- Gives software-free register dumps during bring-up.

---
 rtl/regdump_pkg.sv | 19 +
 rtl/byte_serializer.sv | 59 +++++
 rtl/regfile_dump_reader.sv | 164 ++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-dump streamer.
package regdump_pkg;

    localparam int unsigned REGDUMP_DATA_W = 32;
    localparam int unsigned BYTES_PER_REG  = REGDUMP_DATA_W / 8;
    localparam logic [7:0]  HDR_SYNC       = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWait,
        StCapture,
        StHdr,
        StSend,
        StNext,
        StDone
    } state_e;

endpackage

// File: rtl/byte_serializer.sv
// Parallel-load shift register that emits its contents MS byte first over valid/ready.
module byte_serializer #(
    parameter int unsigned NUM_BYTES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   load_i,
    input  logic [NUM_BYTES*8-1:0] load_data_i,
    input  logic                   flush_i,
    output logic [7:0]             out_data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   fire_o,
    output logic                   last_byte_o
);

    localparam int unsigned W    = NUM_BYTES * 8;
    localparam int unsigned CntW = $clog2(NUM_BYTES + 1);

    logic [W-1:0]    shift_q, shift_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;

    assign fire_o      = valid_q & out_ready_i;
    assign last_byte_o = fire_o && (cnt_q == CntW'(1));
    assign out_data_o  = shift_q[W-1 -: 8];
    assign out_valid_o = valid_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = load_data_i;
            cnt_d   = CntW'(NUM_BYTES);
            valid_d = 1'b1;
        end else if (fire_o) begin
            shift_d = shift_q << 8;
            cnt_d   = cnt_q - CntW'(1);
            // Flush only ever arrives on a handshake, so no byte is cut short.
            if (last_byte_o || flush_i) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register range over the debug read port and streams the contents as bytes.
// Define REGDUMP_HEADER_EN to prefix each register with a sync byte and its address.
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = REGDUMP_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_addr_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] dbg_addr_o,
    input  logic [DATA_W-1:0] dbg_data_i,
    output logic [7:0]        out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned NumDataBytes = DATA_W / 8;
`ifdef REGDUMP_HEADER_EN
    localparam int unsigned NumBytes = NumDataBytes + 2;
`else
    localparam int unsigned NumBytes = NumDataBytes;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
    logic              load, flush, fire, last_byte;
    logic [NumBytes*8-1:0] load_data;

`ifdef REGDUMP_HEADER_EN
    logic hdr_second_q, hdr_second_d;
    assign load_data = {HDR_SYNC, 8'(cur_q), dbg_data_i};
`else
    assign load_data = dbg_data_i;
`endif

    byte_serializer #(
        .NUM_BYTES(NumBytes)
    ) u_ser (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (load),
        .load_data_i (load_data),
        .flush_i     (flush),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .fire_o      (fire),
        .last_byte_o (last_byte)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        end_d      = end_q;
        dbg_addr_d = dbg_addr_q;
        load       = 1'b0;
        flush      = 1'b0;
`ifdef REGDUMP_HEADER_EN
        hdr_second_d = hdr_second_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    cur_d   = first_addr_i;
                    end_d   = last_addr_i;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                dbg_addr_d = cur_q;
                state_d    = abort_i ? StDone : StWait;
            end
            StWait: state_d = abort_i ? StDone : StCapture;
            StCapture: begin
                if (abort_i) begin
                    state_d = StDone;
                end else begin
                    load = 1'b1;
`ifdef REGDUMP_HEADER_EN
                    hdr_second_d = 1'b0;
                    state_d      = StHdr;
`else
                    state_d = StSend;
`endif
                end
            end
            StHdr: begin
`ifdef REGDUMP_HEADER_EN
                if (fire) begin
                    if (abort_i) begin
                        flush   = 1'b1;
                        state_d = StDone;
                    end else if (hdr_second_q) begin
                        state_d = StSend;
                    end else begin
                        hdr_second_d = 1'b1;
                    end
                end
`else
                state_d = StIdle;
`endif
            end
            StSend: begin
                if (fire) begin
                    if (abort_i) begin
                        flush   = 1'b1;
                        state_d = StDone;
                    end else if (last_byte) begin
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                if (abort_i || (cur_q == end_q)) begin
                    state_d = StDone;
                end else begin
                    cur_d   = (cur_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_q + ADDR_W'(1);
                    state_d = StAddr;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cur_q      <= '0;
            end_q      <= '0;
            dbg_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            end_q      <= end_d;
            dbg_addr_q <= dbg_addr_d;
        end
    end

`ifdef REGDUMP_HEADER_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hdr_second_q <= 1'b0;
        end else begin
            hdr_second_q <= hdr_second_d;
        end
    end
`endif

    assign dbg_addr_o = dbg_addr_q;
    assign busy_o     = (state_q != StIdle) && (state_q != StDone);
    assign done_o     = (state_q == StDone);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a registered-read register file model.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [4:0]  last_addr = '0;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [7:0]  out_data;
    logic        out_valid, busy, done;

    logic [31:0] rf [32];
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  ref_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    regfile_dump_reader dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .first_addr_i (first_addr),
        .last_addr_i  (last_addr),
        .abort_i      (abort),
        .dbg_addr_o   (dbg_addr),
        .dbg_data_i   (dbg_data),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dbg_data <= rf[dbg_addr];

    always @(posedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) done_cnt++;
            if (prev_stall && (!out_valid || out_data != prev_data)) stall_err++;
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic add_reg(input int a);
        logic [31:0] v;
        v = rf[a];
`ifdef REGDUMP_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(a));
`endif
        for (int i = 3; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
        end
    endtask

    task automatic run_start(input logic [4:0] f, input logic [4:0] l);
        @(negedge clk);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int base, input int max, input bit rnd, output bit ok);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (done_cnt != base) break;
        end
        ok = (done_cnt != base);
        out_ready = 1'b1;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        ok = out_valid;
    endtask

    initial begin
        bit ok;
        int d0;
        for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 | 32'(i);

        // Reset state
        #12;
        check("rst_dbg_addr", dbg_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-register dump, consumer always ready
        rf[1] = 32'hFFFF_FFE2;
        rf[2] = 32'd56;
        got.delete();
        out_ready = 1'b1;
        d0 = done_cnt;
        run_start(5'd1, 5'd2);
        wait_done(d0, 200, 1'b0, ok);
        check("t1_done_seen", ok, 1);
`ifdef REGDUMP_HEADER_EN
        exp_q = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hE2,
                  8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h38};
`else
        exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hE2, 8'h00, 8'h00, 8'h00, 8'h38};
`endif
        compare_stream("t1");
        repeat (3) @(negedge clk);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_busy_after", busy, 0);

        // Wrapping range 30..1
        rf[30] = 32'd30; rf[31] = 32'd31; rf[0] = 32'd0; rf[1] = 32'd1;
        got.delete(); exp_q.delete();
        add_reg(30); add_reg(31); add_reg(0); add_reg(1);
        d0 = done_cnt;
        run_start(5'd30, 5'd1);
        wait_done(d0, 300, 1'b0, ok);
        check("t2_done_seen", ok, 1);
        compare_stream("t2");
`ifdef REGDUMP_HEADER_EN
        check("t2_total", got.size(), 24);
`else
        check("t2_total", got.size(), 16);
`endif
        if (got.size() > 0) check("t2_last_byte", got[got.size()-1], 8'h01);

        // Four registers, first steady then with random backpressure
        rf[4] = 32'h0102_0304; rf[5] = 32'hA0B0_C0D0;
        rf[6] = 32'hDEAD_BEEF; rf[7] = 32'h5A5A_0F0F;
        got.delete(); exp_q.delete();
        for (int a = 4; a <= 7; a++) add_reg(a);
        d0 = done_cnt;
        run_start(5'd4, 5'd7);
        wait_done(d0, 300, 1'b0, ok);
        check("t3_ready_done", ok, 1);
        compare_stream("t3_ready");
        ref_q = got;
        got.delete();
        stall_err = 0;
        d0 = done_cnt;
        run_start(5'd4, 5'd7);
        wait_done(d0, 1000, 1'b1, ok);
        check("t3_rand_done", ok, 1);
        exp_q = ref_q;
        compare_stream("t3_rand");
        check("t3_stall_stable", stall_err, 0);

        // Abort while the second byte of register 5 is stalled
        rf[5] = 32'h1122_3344;
        got.delete(); exp_q.delete();
`ifdef REGDUMP_HEADER_EN
        exp_q = '{8'hA5, 8'h05};
`else
        exp_q = '{8'h11, 8'h22};
`endif
        out_ready = 1'b0;
        d0 = done_cnt;
        run_start(5'd5, 5'd6);
        wait_valid(50, ok);
        check("t4_valid_seen", ok, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_hold_valid", out_valid, 1);
        check("t4_hold_data", out_data, exp_q[1]);
        check("t4_hold_busy", busy, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        wait_done(d0, 20, 1'b0, ok);
        check("t4_done_seen", ok, 1);
        abort = 1'b0;
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        compare_stream("t4");
        check("t4_done_pulses", done_cnt - d0, 1);
        check("t4_busy_after", busy, 0);
        check("t4_valid_after", out_valid, 0);

        // Asynchronous reset in the middle of SEND
        out_ready = 1'b0;
        run_start(5'd8, 5'd9);
        wait_valid(50, ok);
        check("t5_valid_seen", ok, 1);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);

        // Normal single-register dump after reset; a start while busy is ignored
        got.delete(); exp_q.delete();
        add_reg(2);
        out_ready = 1'b0;
        d0 = done_cnt;
        run_start(5'd2, 5'd2);
        repeat (2) @(negedge clk);
        check("t6_busy", busy, 1);
        run_start(5'd9, 5'd12);
        out_ready = 1'b1;
        wait_done(d0, 100, 1'b0, ok);
        check("t6_done_seen", ok, 1);
        repeat (20) @(negedge clk);
        compare_stream("t6");
        check("t6_done_pulses", done_cnt - d0, 1);
        check("t6_dbg_addr_hold", dbg_addr, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
